// File: rtl/ltc_sync_ctrl_pkg.sv
// Shared definitions for the ICM time-transfer supervisor: FSM encoding seen by software and default widths.
// No logic, no latency, no backpressure.
package ltc_sync_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_ACQUIRE = 3'd1,
        ST_LOCKED  = 3'd2,
        ST_HOLDOFF = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    localparam int CNT_W_DEF = 16;
    localparam int LTC_W     = 48;

    // Decoder is enabled exactly in the two acquisition-related states.
    function automatic logic tt_en_state(input state_t s);
        return (s == ST_ACQUIRE) || (s == ST_LOCKED);
    endfunction

endpackage

// File: rtl/ltc_sync_ctrl_if.sv
// Bundle of software, decoder and mainboard-LTC signals around the supervisor.
// slave = supervisor view, master = the driving/observing side.
interface ltc_sync_ctrl_if #(
    parameter int CNT_W = 16
);
    logic              sw_en;
    logic              sw_ltc_wr_req;
    logic [47:0]       sw_ltc_wr_data;
    logic              tt_rdy;
    logic              tt_err;
    logic              tt_ltc_wr_req;
    logic [47:0]       tt_ltc_wr_data;
    logic              tt_en;
    logic              ltc_wr_req;
    logic [47:0]       ltc_wr_data;
    logic              sw_wr_rej;
    logic              locked;
    logic              fault;
    logic [2:0]        state;
    logic [CNT_W-1:0]  lock_loss_cnt;
    logic [CNT_W-1:0]  retry_cnt_tot;
    logic [CNT_W-1:0]  sw_rej_cnt;

    modport slave (
        input  sw_en, sw_ltc_wr_req, sw_ltc_wr_data,
        input  tt_rdy, tt_err, tt_ltc_wr_req, tt_ltc_wr_data,
        output tt_en, ltc_wr_req, ltc_wr_data, sw_wr_rej, locked, fault, state,
        output lock_loss_cnt, retry_cnt_tot, sw_rej_cnt
    );

    modport master (
        output sw_en, sw_ltc_wr_req, sw_ltc_wr_data,
        output tt_rdy, tt_err, tt_ltc_wr_req, tt_ltc_wr_data,
        input  tt_en, ltc_wr_req, ltc_wr_data, sw_wr_rej, locked, fault, state,
        input  lock_loss_cnt, retry_cnt_tot, sw_rej_cnt
    );

endinterface

// File: rtl/ltc_sync_ctrl_sat_counter.sv
// Saturating event counter: increments on i_en, sticks at all-ones, cleared only by reset.
// Count visible 1 cycle after the enable; no backpressure.
module ltc_sync_ctrl_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/ltc_sync_ctrl.sv
// Supervises the ICM time-transfer decoder (acquire/lock/holdoff/fault) and arbitrates the single LTC write port.
// All outputs registered; LTC write follows an accepted request by 1 cycle; no backpressure, decoder wins over software.
module ltc_sync_ctrl
    import ltc_sync_ctrl_pkg::*;
#(
    parameter logic [31:0] SYNC_TIMEOUT  = 32'd240000000,
    parameter logic [15:0] RETRY_HOLDOFF = 16'd4096,
    parameter logic [3:0]  MAX_RETRY     = 4'd3,
    parameter int          CNT_W         = CNT_W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    ltc_sync_ctrl_if.slave bus
);
    localparam logic [31:0] TMO_LAST = SYNC_TIMEOUT - 32'd1;
    localparam logic [31:0] HO_LAST  = {16'd0, RETRY_HOLDOFF} - 32'd1;

    state_t           r_state, w_nxt_state;
    logic [31:0]      r_timer, w_nxt_timer, w_run_timer;
    logic [3:0]       r_retry, w_nxt_retry, w_retry_inc;
    logic             r_tt_en, r_locked, r_fault, r_sw_wr_rej, r_ltc_wr_req;
    logic [LTC_W-1:0] r_ltc_wr_data, r_pend_dat, w_sw_dat, w_nxt_pend_dat;
    logic             r_pend_vld, w_nxt_pend_vld;
    logic             w_dec_acc, w_sw_ok, w_sw_new, w_sw_rej, w_sw_vld, w_sw_iss;
    logic             w_tmo, w_lock_loss, w_ho_enter;
    logic [CNT_W-1:0] w_lock_loss_cnt, w_retry_cnt_tot, w_sw_rej_cnt;

    // Registered tt_en gates the decoder strobe so a pulse racing tt_en falling is ignored.
    assign w_dec_acc   = bus.tt_ltc_wr_req && r_tt_en;
    assign w_sw_ok     = (r_state == ST_OFF) || (r_state == ST_HOLDOFF) || (r_state == ST_FAULT);
    assign w_sw_new    = bus.sw_ltc_wr_req && w_sw_ok;
    assign w_sw_rej    = bus.sw_ltc_wr_req && !w_sw_ok;
    assign w_sw_vld    = w_sw_new || r_pend_vld;
    assign w_sw_dat    = w_sw_new ? bus.sw_ltc_wr_data : r_pend_dat;
    assign w_sw_iss    = w_sw_vld && !w_dec_acc;
    assign w_tmo       = (r_timer == TMO_LAST) && !w_dec_acc;
    assign w_run_timer = w_dec_acc ? 32'd0 : r_timer + 32'd1;
    assign w_retry_inc = r_retry + 4'd1;
    assign w_ho_enter  = (w_nxt_state == ST_HOLDOFF) && (r_state != ST_HOLDOFF);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_timer = r_timer;
        w_nxt_retry = r_retry;
        w_lock_loss = 1'b0;
        if (!bus.sw_en) begin
            w_nxt_state = ST_OFF;
            w_nxt_timer = 32'd0;
            w_nxt_retry = 4'd0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_nxt_state = ST_ACQUIRE;
                    w_nxt_timer = 32'd0;
                end
                ST_ACQUIRE: begin
                    w_nxt_timer = w_run_timer;
                    if (bus.tt_rdy) begin
                        w_nxt_state = ST_LOCKED;
                        w_nxt_retry = 4'd0;
                    end else if (w_tmo) begin
                        w_nxt_retry = w_retry_inc;
                        w_nxt_state = (w_retry_inc == MAX_RETRY) ? ST_FAULT : ST_HOLDOFF;
                        w_nxt_timer = 32'd0;
                    end
                end
                ST_LOCKED: begin
                    w_nxt_timer = w_run_timer;
                    // Timeout outranks err/rdy loss: the decoder gets a full restart.
                    if (w_tmo) begin
                        w_nxt_state = ST_HOLDOFF;
                        w_nxt_timer = 32'd0;
                        w_lock_loss = 1'b1;
                    end else if (bus.tt_err || !bus.tt_rdy) begin
                        w_nxt_state = ST_ACQUIRE;
                        w_lock_loss = 1'b1;
                    end
                end
                ST_HOLDOFF: begin
                    if (r_timer == HO_LAST) begin
                        w_nxt_state = ST_ACQUIRE;
                        w_nxt_timer = 32'd0;
                    end else begin
                        w_nxt_timer = r_timer + 32'd1;
                    end
                end
                ST_FAULT: begin
                    w_nxt_timer = 32'd0;
                end
                default: begin
                    w_nxt_state = ST_OFF;
                    w_nxt_timer = 32'd0;
                    w_nxt_retry = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        w_nxt_pend_vld = 1'b0;
        w_nxt_pend_dat = r_pend_dat;
        if (bus.sw_en && w_sw_vld && !w_sw_iss &&
            !((w_nxt_state == ST_ACQUIRE) && (r_state != ST_ACQUIRE))) begin
            w_nxt_pend_vld = 1'b1;
            w_nxt_pend_dat = w_sw_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_OFF;
            r_timer       <= 32'd0;
            r_retry       <= 4'd0;
            r_tt_en       <= 1'b0;
            r_locked      <= 1'b0;
            r_fault       <= 1'b0;
            r_sw_wr_rej   <= 1'b0;
            r_ltc_wr_req  <= 1'b0;
            r_ltc_wr_data <= '0;
            r_pend_vld    <= 1'b0;
            r_pend_dat    <= '0;
        end else begin
            r_state       <= w_nxt_state;
            r_timer       <= w_nxt_timer;
            r_retry       <= w_nxt_retry;
            r_tt_en       <= tt_en_state(w_nxt_state);
            r_locked      <= (w_nxt_state == ST_LOCKED);
            r_fault       <= (w_nxt_state == ST_FAULT);
            r_sw_wr_rej   <= w_sw_rej;
            r_ltc_wr_req  <= w_dec_acc || w_sw_iss;
            r_ltc_wr_data <= w_dec_acc ? bus.tt_ltc_wr_data : (w_sw_iss ? w_sw_dat : '0);
            r_pend_vld    <= w_nxt_pend_vld;
            r_pend_dat    <= w_nxt_pend_dat;
        end
    end

    ltc_sync_ctrl_sat_counter #(.W(CNT_W)) u_lock_loss_cnt (
        .clk(clk), .rst_n(rst_n), .i_en(w_lock_loss), .o_cnt(w_lock_loss_cnt)
    );
    ltc_sync_ctrl_sat_counter #(.W(CNT_W)) u_retry_cnt_tot (
        .clk(clk), .rst_n(rst_n), .i_en(w_ho_enter), .o_cnt(w_retry_cnt_tot)
    );
    ltc_sync_ctrl_sat_counter #(.W(CNT_W)) u_sw_rej_cnt (
        .clk(clk), .rst_n(rst_n), .i_en(w_sw_rej), .o_cnt(w_sw_rej_cnt)
    );

    assign bus.tt_en         = r_tt_en;
    assign bus.ltc_wr_req    = r_ltc_wr_req;
    assign bus.ltc_wr_data   = r_ltc_wr_data;
    assign bus.sw_wr_rej     = r_sw_wr_rej;
    assign bus.locked        = r_locked;
    assign bus.fault         = r_fault;
    assign bus.state         = r_state;
    assign bus.lock_loss_cnt = w_lock_loss_cnt;
    assign bus.retry_cnt_tot = w_retry_cnt_tot;
    assign bus.sw_rej_cnt    = w_sw_rej_cnt;

endmodule

// File: tb/tb_ltc_sync_ctrl.sv
// Directed bench for ltc_sync_ctrl with short timeouts (100 / 8 / 2).
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_ltc_sync_ctrl;
    import ltc_sync_ctrl_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    localparam logic [47:0] SW_DAT  = 48'h0000_1234_5678;
    localparam logic [47:0] DEC_BAS = 48'h0000_DEC0_0000;

    ltc_sync_ctrl_if #(.CNT_W(16)) bus ();

    ltc_sync_ctrl #(
        .SYNC_TIMEOUT (32'd100),
        .RETRY_HOLDOFF(16'd8),
        .MAX_RETRY    (4'd2),
        .CNT_W        (16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"},     bus.state,         64'd0);
        chk({tag, "_tt_en"},     bus.tt_en,         64'd0);
        chk({tag, "_wr_req"},    bus.ltc_wr_req,    64'd0);
        chk({tag, "_wr_dat"},    bus.ltc_wr_data,   64'd0);
        chk({tag, "_rej"},       bus.sw_wr_rej,     64'd0);
        chk({tag, "_locked"},    bus.locked,        64'd0);
        chk({tag, "_fault"},     bus.fault,         64'd0);
        chk({tag, "_lock_loss"}, bus.lock_loss_cnt, 64'd0);
        chk({tag, "_retry_tot"}, bus.retry_cnt_tot, 64'd0);
        chk({tag, "_sw_rej"},    bus.sw_rej_cnt,    64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sw_en = 0; bus.sw_ltc_wr_req = 0; bus.sw_ltc_wr_data = '0;
        bus.tt_rdy = 0; bus.tt_err = 0; bus.tt_ltc_wr_req = 0; bus.tt_ltc_wr_data = '0;
        steps(3);
        chk_all_zero("rst");
        rst_n = 1'b1;

        // Acquire with decoder writes every 50 cycles, rdy from cycle 60.
        bus.sw_en = 1;
        for (int c = 0; c < 120; c++) begin
            bus.tt_ltc_wr_req  = (c % 50 == 10);
            bus.tt_ltc_wr_data = DEC_BAS | 48'(c);
            bus.tt_rdy         = (c >= 60);
            step();
            chk("t1_state",  bus.state,       (c < 60) ? 64'd1 : 64'd2);
            chk("t1_wr_req", bus.ltc_wr_req,  (c % 50 == 10) ? 64'd1 : 64'd0);
            chk("t1_wr_dat", bus.ltc_wr_data, (c % 50 == 10) ? 64'(DEC_BAS | 48'(c)) : 64'd0);
        end
        bus.tt_ltc_wr_req = 0;
        chk("t1_locked", bus.locked, 1);
        chk("t1_tt_en",  bus.tt_en, 1);
        chk("t1_sw_rej", bus.sw_rej_cnt, 0);
        chk("t1_lloss",  bus.lock_loss_cnt, 0);

        // Lock loss by error, then by rdy drop.
        bus.tt_err = 1; step(); bus.tt_err = 0;
        chk("t3_err_state", bus.state, 1);
        chk("t3_err_lloss", bus.lock_loss_cnt, 1);
        chk("t3_err_tt_en", bus.tt_en, 1);
        step();
        chk("t3_relock", bus.state, 2);
        bus.tt_rdy = 0; step();
        chk("t3_rdy_state", bus.state, 1);
        chk("t3_rdy_lloss", bus.lock_loss_cnt, 2);
        chk("t3_rdy_tt_en", bus.tt_en, 1);
        bus.tt_rdy = 1; step();
        chk("t3_relock2", bus.state, 2);

        // Software write while LOCKED is rejected.
        bus.sw_ltc_wr_req = 1; bus.sw_ltc_wr_data = SW_DAT; step(); bus.sw_ltc_wr_req = 0;
        chk("t4_rej",     bus.sw_wr_rej, 1);
        chk("t4_rej_cnt", bus.sw_rej_cnt, 1);
        chk("t4_no_wr",   bus.ltc_wr_req, 0);
        step();
        chk("t4_rej_end", bus.sw_wr_rej, 0);
        chk("t4_no_wr2",  bus.ltc_wr_req, 0);

        // Disable, then software write in OFF.
        bus.sw_en = 0; step();
        chk("off_state", bus.state, 0);
        chk("off_tt_en", bus.tt_en, 0);
        chk("off_lloss", bus.lock_loss_cnt, 2);
        bus.sw_ltc_wr_req = 1; bus.sw_ltc_wr_data = SW_DAT; step(); bus.sw_ltc_wr_req = 0;
        chk("t4_wr_req", bus.ltc_wr_req, 1);
        chk("t4_wr_dat", bus.ltc_wr_data, SW_DAT);
        chk("t4_no_rej", bus.sw_wr_rej, 0);
        step();
        chk("t4_wr_end", bus.ltc_wr_req, 0);
        chk("t4_dat_0",  bus.ltc_wr_data, 0);

        // Acquire timeout -> holdoff, stale decoder pulse masked, second timeout -> fault.
        bus.tt_rdy = 0; bus.sw_en = 1; step();
        chk("t2_acq", bus.state, 1);
        steps(99);
        chk("t2_pre_tmo", bus.state, 1);
        step();
        chk("t2_ho_state", bus.state, 3);
        chk("t2_ho_tt_en", bus.tt_en, 0);
        chk("t2_retry1",   bus.retry_cnt_tot, 1);
        for (int k = 1; k <= 8; k++) begin
            if (k == 3) begin
                bus.tt_ltc_wr_req = 1; bus.tt_ltc_wr_data = 48'hBAD0_BAD0_BAD0;
                bus.sw_ltc_wr_req = 1; bus.sw_ltc_wr_data = 48'h5EED_0000_00A5;
            end
            step();
            bus.tt_ltc_wr_req = 0; bus.sw_ltc_wr_req = 0;
            if (k == 3) begin
                chk("t5_wr_req", bus.ltc_wr_req, 1);
                chk("t5_wr_dat", bus.ltc_wr_data, 48'h5EED_0000_00A5);
            end
            chk("t2_ho_state_k", bus.state, (k < 8) ? 64'd3 : 64'd1);
            chk("t2_ho_tt_en_k", bus.tt_en, (k < 8) ? 64'd0 : 64'd1);
        end
        steps(99);
        chk("t2_pre_tmo2", bus.state, 1);
        step();
        chk("t2_fault_state", bus.state, 4);
        chk("t2_fault",       bus.fault, 1);
        chk("t2_fault_tt_en", bus.tt_en, 0);
        chk("t2_retry_tot",   bus.retry_cnt_tot, 1);
        bus.sw_ltc_wr_req = 1; bus.sw_ltc_wr_data = 48'hFA01_0000_0042; step(); bus.sw_ltc_wr_req = 0;
        chk("fault_sw_wr",  bus.ltc_wr_req, 1);
        chk("fault_sw_dat", bus.ltc_wr_data, 48'hFA01_0000_0042);
        bus.sw_en = 0; step();
        chk("t2_off_state", bus.state, 0);
        chk("t2_off_fault", bus.fault, 0);

        // LOCKED timeout coinciding with tt_err: timeout wins, one lock-loss count.
        bus.tt_rdy = 1; bus.sw_en = 1; step();
        chk("lt_acq", bus.state, 1);
        step();
        chk("lt_locked", bus.state, 2);
        steps(98);
        chk("lt_pre_tmo", bus.state, 2);
        bus.tt_err = 1; step(); bus.tt_err = 0;
        chk("lt_ho_state", bus.state, 3);
        chk("lt_lloss",    bus.lock_loss_cnt, 3);
        chk("lt_retry",    bus.retry_cnt_tot, 2);
        steps(8);
        chk("lt_reacq", bus.state, 1);
        step();
        chk("lt_relock", bus.state, 2);

        // Asynchronous reset mid-LOCKED.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("arst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
